// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, field positions and state encoding for the CPU sequencer
package cpu_pkg;

  localparam int XLEN = 24;

  localparam int OP_MSB  = 23;
  localparam int OP_LSB  = 20;
  localparam int RY_MSB  = 19;
  localparam int RY_LSB  = 16;
  localparam int RA_MSB  = 15;
  localparam int RA_LSB  = 12;
  localparam int RB_MSB  = 11;
  localparam int RB_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_INV  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_JMP  = 4'b0111;
  localparam logic [3:0] OP_NOP  = 4'b1000;
  localparam logic [3:0] OP_LD   = 4'b1010;
  localparam logic [3:0] OP_ST   = 4'b1011;
  localparam logic [3:0] OP_ADDI = 4'b1100;
  localparam logic [3:0] OP_MULI = 4'b1101;

  // Code presented to the ALU whenever no ALU instruction is executing.
  localparam logic [3:0] ALU_NOP = 4'b1000;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_MEM    = 2'd3
  } state_t;

endpackage

// File: rtl/cpu_instr_fields.sv
// rtl/cpu_instr_fields.sv - combinational split and classification of the instruction register
module cpu_instr_fields
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] ir,
  output logic [3:0]      opcode,
  output logic [3:0]      ry,
  output logic [3:0]      ra,
  output logic [3:0]      rb,
  output logic [7:0]      imm,
  output logic            is_alu,
  output logic            is_mem,
  output logic            is_ld,
  output logic            is_st,
  output logic            is_jmp,
  output logic            is_reserved
);

  assign opcode = ir[OP_MSB:OP_LSB];
  assign ry     = ir[RY_MSB:RY_LSB];
  assign ra     = ir[RA_MSB:RA_LSB];
  assign rb     = ir[RB_MSB:RB_LSB];
  assign imm    = ir[IMM_MSB:IMM_LSB];

  always_comb begin
    is_alu      = 1'b0;
    is_ld       = 1'b0;
    is_st       = 1'b0;
    is_jmp      = 1'b0;
    is_reserved = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_MUL, OP_XOR,
      OP_INV, OP_AND, OP_OR,
      OP_ADDI, OP_MULI: is_alu = 1'b1;
      OP_JMP:           is_jmp = 1'b1;
      OP_NOP:           ;
      OP_LD:            is_ld = 1'b1;
      OP_ST:            is_st = 1'b1;
      default:          is_reserved = 1'b1;
    endcase
  end

  assign is_mem = is_ld | is_st;

endmodule

// File: rtl/cpu_control_fsm.sv
// rtl/cpu_control_fsm.sv - multi-cycle fetch/decode/exec/mem sequencer owning the program counter
module cpu_control_fsm
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_RESET = 24'h000000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] ra_data,
  output logic [3:0]      alu_control,
  output logic [7:0]      abs_val,
  output logic [3:0]      ra_sel,
  output logic [3:0]      rb_sel,
  output logic [3:0]      ry_sel,
  output logic            rf_we,
  output logic            wb_sel,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  input  logic            dmem_ack,
  output logic            illegal_op
);

  state_t          state;
  state_t          next_state;
  logic [XLEN-1:0] ir;

  logic [3:0] f_opcode;
  logic [3:0] f_ry;
  logic [3:0] f_ra;
  logic [3:0] f_rb;
  logic [7:0] f_imm;
  logic       f_is_alu;
  logic       f_is_mem;
  logic       f_is_ld;
  logic       f_is_st;
  logic       f_is_jmp;
  logic       f_is_reserved;

  logic imem_fire;
  logic dmem_fire;

  cpu_instr_fields u_fields (
    .ir          (ir),
    .opcode      (f_opcode),
    .ry          (f_ry),
    .ra          (f_ra),
    .rb          (f_rb),
    .imm         (f_imm),
    .is_alu      (f_is_alu),
    .is_mem      (f_is_mem),
    .is_ld       (f_is_ld),
    .is_st       (f_is_st),
    .is_jmp      (f_is_jmp),
    .is_reserved (f_is_reserved)
  );

  // Acks only count while the matching request is actually on the wire.
  assign imem_fire = (state == ST_FETCH) && imem_req && imem_ack;
  assign dmem_fire = (state == ST_MEM) && dmem_req && dmem_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_FETCH:  if (imem_fire) next_state = ST_DECODE;
      ST_DECODE: next_state = ST_EXEC;
      ST_EXEC:   next_state = f_is_mem ? ST_MEM : ST_FETCH;
      ST_MEM:    if (dmem_fire) next_state = ST_FETCH;
      default:   next_state = ST_FETCH;
    endcase
  end

  // Requests are registered off next_state so they rise with entry to the
  // waiting state and fall the cycle after the accepting ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir         <= '0;
      pc         <= PC_RESET;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      rf_we      <= 1'b0;
      wb_sel     <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      if (imem_fire) begin
        ir <= imem_rdata;
      end
      imem_req <= (next_state == ST_FETCH);
      dmem_req <= (next_state == ST_MEM);
      dmem_we  <= (next_state == ST_MEM) && f_is_st;
      if ((state == ST_EXEC) && f_is_mem) begin
        dmem_addr <= ra_data;
      end
      rf_we      <= ((state == ST_DECODE) && f_is_alu) || (dmem_fire && f_is_ld);
      wb_sel     <= dmem_fire && f_is_ld;
      illegal_op <= (state == ST_DECODE) && f_is_reserved;
      if (state == ST_EXEC) begin
        if (f_is_jmp) begin
          pc <= ra_data;
        end else if (!f_is_mem) begin
          pc <= pc + XLEN'(1);
        end
      end else if (dmem_fire) begin
        pc <= pc + XLEN'(1);
      end
    end
  end

  // Loads write back to the Rb register, so the write select follows it.
  always_comb begin
    alu_control = ALU_NOP;
    if ((state == ST_EXEC) && f_is_alu) begin
      alu_control = f_opcode;
    end
    abs_val = f_imm;
    ra_sel  = f_ra;
    rb_sel  = f_rb;
    ry_sel  = f_is_ld ? f_rb : f_ry;
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb/tb_cpu_control_fsm.sv - directed self-checking bench for the CPU control sequencer
module tb_cpu_control_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic        imem_ack;
  logic [23:0] imem_rdata;
  logic [23:0] pc;
  logic [23:0] ra_data;
  logic [3:0]  alu_control;
  logic [7:0]  abs_val;
  logic [3:0]  ra_sel;
  logic [3:0]  rb_sel;
  logic [3:0]  ry_sel;
  logic        rf_we;
  logic        wb_sel;
  logic        dmem_req;
  logic        dmem_we;
  logic [23:0] dmem_addr;
  logic        dmem_ack;
  logic        illegal_op;

  int checks   = 0;
  int failures = 0;

  cpu_control_fsm #(.PC_RESET(24'h000000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .ra_data     (ra_data),
    .alu_control (alu_control),
    .abs_val     (abs_val),
    .ra_sel      (ra_sel),
    .rb_sel      (rb_sel),
    .ry_sel      (ry_sel),
    .rf_we       (rf_we),
    .wb_sel      (wb_sel),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_ack    (dmem_ack),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  // Waits (bounded) for imem_req, presents the word with a same-cycle ack, returns at the DECODE negedge.
  task automatic fetch_instr(input logic [23:0] w);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (imem_req !== 1'b1) begin failures++; $display("FAIL fetch_wait imem_req=%b required=1", imem_req); end
    imem_ack   = 1'b1;
    imem_rdata = w;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (pc !== 24'h0) begin failures++; $display("FAIL reset_pc got=%h required=%h", pc, 24'h0); end
    checks++; if (alu_control !== 4'b1000) begin failures++; $display("FAIL reset_alu got=%b required=1000", alu_control); end
    checks++; if ({imem_req, dmem_req, dmem_we, rf_we, wb_sel, illegal_op} !== 6'b0) begin failures++; $display("FAIL reset_strobes got=%b required=000000", {imem_req, dmem_req, dmem_we, rf_we, wb_sel, illegal_op}); end
    checks++; if ({abs_val, ra_sel, rb_sel, ry_sel} !== 20'h0) begin failures++; $display("FAIL reset_fields got=%h required=00000", {abs_val, ra_sel, rb_sel, ry_sel}); end
    checks++; if (dmem_addr !== 24'h0) begin failures++; $display("FAIL reset_dmem_addr got=%h required=000000", dmem_addr); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL reset_first_req got=%b required=1", imem_req); end
  endtask

  task automatic test_add();
    fetch_instr(24'h031200);
    checks++; if ({ry_sel, ra_sel, rb_sel} !== 12'h312) begin failures++; $display("FAIL add_sels got=%h required=312", {ry_sel, ra_sel, rb_sel}); end
    checks++; if (alu_control !== 4'b1000 || rf_we !== 1'b0) begin failures++; $display("FAIL add_decode alu=%b rf_we=%b required 1000/0", alu_control, rf_we); end
    @(negedge clk);
    checks++; if (alu_control !== 4'b0000) begin failures++; $display("FAIL add_alu got=%b required=0000", alu_control); end
    checks++; if (rf_we !== 1'b1 || wb_sel !== 1'b0) begin failures++; $display("FAIL add_wb rf_we=%b wb_sel=%b required 1/0", rf_we, wb_sel); end
    @(negedge clk);
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL add_rf_we_pulse got=%b required=0", rf_we); end
    checks++; if (pc !== 24'h1) begin failures++; $display("FAIL add_pc got=%h required=000001", pc); end
    checks++; if (alu_control !== 4'b1000) begin failures++; $display("FAIL add_alu_after got=%b required=1000", alu_control); end
  endtask

  task automatic test_addi();
    fetch_instr(24'hC5407F);
    checks++; if (abs_val !== 8'h7F) begin failures++; $display("FAIL addi_imm got=%h required=7f", abs_val); end
    @(negedge clk);
    checks++; if (alu_control !== 4'b1100) begin failures++; $display("FAIL addi_alu got=%b required=1100", alu_control); end
    checks++; if (ry_sel !== 4'd5 || rf_we !== 1'b1) begin failures++; $display("FAIL addi_dest ry=%0d rf_we=%b required 5/1", ry_sel, rf_we); end
    @(negedge clk);
    checks++; if (pc !== 24'h2) begin failures++; $display("FAIL addi_pc got=%h required=000002", pc); end
  endtask

  task automatic test_jmp_wrap();
    ra_data = 24'h000040;
    fetch_instr(24'h700000);
    @(negedge clk);
    checks++; if (rf_we !== 1'b0 || alu_control !== 4'b1000) begin failures++; $display("FAIL jmp_exec rf_we=%b alu=%b required 0/1000", rf_we, alu_control); end
    @(negedge clk);
    checks++; if (pc !== 24'h000040) begin failures++; $display("FAIL jmp_pc got=%h required=000040", pc); end
    ra_data = 24'hFFFFFF;
    fetch_instr(24'h700000);
    @(negedge clk);
    @(negedge clk);
    checks++; if (pc !== 24'hFFFFFF) begin failures++; $display("FAIL jmp_pc_top got=%h required=ffffff", pc); end
    fetch_instr(24'h800000);
    @(negedge clk);
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL nop_rf_we got=%b required=0", rf_we); end
    @(negedge clk);
    checks++; if (pc !== 24'h0) begin failures++; $display("FAIL nop_wrap_pc got=%h required=000000", pc); end
  endtask

  task automatic test_ld();
    int held;
    held    = 0;
    ra_data = 24'h000100;
    fetch_instr(24'hA02600);
    @(negedge clk);
    checks++; if (dmem_req !== 1'b0 || rf_we !== 1'b0) begin failures++; $display("FAIL ld_exec dmem_req=%b rf_we=%b required 0/0", dmem_req, rf_we); end
    @(negedge clk);
    checks++; if (dmem_addr !== 24'h000100 || dmem_we !== 1'b0) begin failures++; $display("FAIL ld_mem addr=%h we=%b required 000100/0", dmem_addr, dmem_we); end
    ra_data = 24'h000999;
    for (int i = 0; i < 4; i++) begin
      if (dmem_req === 1'b1 && rf_we === 1'b0) held++;
      if (i == 3) dmem_ack = 1'b1;
      @(negedge clk);
    end
    dmem_ack = 1'b0;
    checks++; if (held !== 4) begin failures++; $display("FAIL ld_req_held got=%0d required=4", held); end
    checks++; if (rf_we !== 1'b1 || wb_sel !== 1'b1) begin failures++; $display("FAIL ld_wb rf_we=%b wb_sel=%b required 1/1", rf_we, wb_sel); end
    checks++; if (ry_sel !== 4'd6) begin failures++; $display("FAIL ld_dest got=%0d required=6", ry_sel); end
    checks++; if (dmem_req !== 1'b0 || pc !== 24'h1) begin failures++; $display("FAIL ld_done dmem_req=%b pc=%h required 0/000001", dmem_req, pc); end
    checks++; if (dmem_addr !== 24'h000100) begin failures++; $display("FAIL ld_addr_latch got=%h required=000100", dmem_addr); end
    @(negedge clk);
    checks++; if (rf_we !== 1'b0 || wb_sel !== 1'b0) begin failures++; $display("FAIL ld_pulse rf_we=%b wb_sel=%b required 0/0", rf_we, wb_sel); end
  endtask

  task automatic test_st();
    ra_data = 24'h000100;
    fetch_instr(24'hB02600);
    @(negedge clk);
    @(negedge clk);
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin failures++; $display("FAIL st_mem req=%b we=%b required 1/1", dmem_req, dmem_we); end
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    checks++; if (rf_we !== 1'b0 || dmem_req !== 1'b0) begin failures++; $display("FAIL st_done rf_we=%b req=%b required 0/0", rf_we, dmem_req); end
    checks++; if (pc !== 24'h2) begin failures++; $display("FAIL st_pc got=%h required=000002", pc); end
  endtask

  task automatic test_reserved();
    fetch_instr(24'hE00000);
    checks++; if (illegal_op !== 1'b0) begin failures++; $display("FAIL rsv_early got=%b required=0", illegal_op); end
    @(negedge clk);
    checks++; if (illegal_op !== 1'b1 || rf_we !== 1'b0) begin failures++; $display("FAIL rsv_exec illegal=%b rf_we=%b required 1/0", illegal_op, rf_we); end
    @(negedge clk);
    checks++; if (illegal_op !== 1'b0 || pc !== 24'h3) begin failures++; $display("FAIL rsv_after illegal=%b pc=%h required 0/000003", illegal_op, pc); end
  endtask

  task automatic test_reset_in_mem();
    ra_data = 24'h000200;
    fetch_instr(24'hA02600);
    @(negedge clk);
    @(negedge clk);
    checks++; if (dmem_req !== 1'b1) begin failures++; $display("FAIL rstmem_req got=%b required=1", dmem_req); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (dmem_req !== 1'b0 || pc !== 24'h0) begin failures++; $display("FAIL rstmem_drop req=%b pc=%h required 0/000000", dmem_req, pc); end
    rst      = 1'b0;
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    checks++; if (rf_we !== 1'b0 || dmem_req !== 1'b0) begin failures++; $display("FAIL rstmem_late_ack rf_we=%b req=%b required 0/0", rf_we, dmem_req); end
    @(negedge clk);
    checks++; if (rf_we !== 1'b0 || imem_req !== 1'b1) begin failures++; $display("FAIL rstmem_refetch rf_we=%b imem_req=%b required 0/1", rf_we, imem_req); end
  endtask

  task automatic test_back_to_back();
    fetch_instr(24'h1ABC00);
    @(negedge clk);
    checks++; if (alu_control !== 4'b0001 || ry_sel !== 4'hA) begin failures++; $display("FAIL b2b_sub alu=%b ry=%h required 0001/a", alu_control, ry_sel); end
    @(negedge clk);
    fetch_instr(24'h600000);
    @(negedge clk);
    checks++; if (alu_control !== 4'b0110 || rf_we !== 1'b1) begin failures++; $display("FAIL b2b_or alu=%b rf_we=%b required 0110/1", alu_control, rf_we); end
    @(negedge clk);
    checks++; if (pc !== 24'h2) begin failures++; $display("FAIL b2b_pc got=%h required=000002", pc); end
  endtask

  initial begin
    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    ra_data    = '0;
    dmem_ack   = 1'b0;
    test_reset();
    test_add();
    test_addi();
    test_jmp_wrap();
    test_ld();
    test_st();
    test_reserved();
    test_reset_in_mem();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Multi-cycle control sequencer for the 24-bit CPU. It owns the program counter, fetches one 24-bit instruction per pass, decodes it, and issues the 4-bit ALU control code, register selects and 8-bit immediate to the datapath ALU. It also executes the operations the ALU delegates elsewhere: the jump (PC ← Ra) and LD/ST data-memory handshakes.

## Interface
- `PC_RESET`, default 24'h000000: PC value after reset.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `imem_req`  out  1  instruction fetch request, held until ack
- `imem_ack`  in  1  instruction word valid this cycle
- `imem_rdata`  in  24  instruction word
- `pc`  out  24  current instruction address
- `ra_data`  in  24  register-file read of Ra (jump target / memory address)
- `alu_control`  out  4  ALU operation code
- `abs_val`  out  8  immediate field
- `ra_sel`, `rb_sel`, `ry_sel`  out  4 each  register-file selects
- `rf_we`  out  1  register-file write strobe, one cycle
- `wb_sel`  out  1  0 = ALU result, 1 = memory read data
- `dmem_req`  out  1  data-memory request, held until ack
- `dmem_we`  out  1  1 = store, valid with `dmem_req`
- `dmem_addr`  out  24  equals `ra_data` latched in EXEC
- `dmem_ack`  in  1  data-memory transfer complete
- `illegal_op`  out  1  one-cycle pulse on a reserved opcode

## Operation
- Instruction format: [23:20] opcode, [19:16] Ry, [15:12] Ra, [11:8] Rb, [7:0] Imm.
- Opcodes: 0000 ADD, 0001 SUB, 0010 MUL, 0011 XOR, 0100 INV, 0101 AND, 0110 OR, 0111 JMP, 1000 NOP, 1010 LD, 1011 ST, 1100 ADDI, 1101 MULI; 1001/1110/1111 reserved.
- States: FETCH → DECODE → EXEC → (MEM for LD/ST) → FETCH.
- FETCH: `imem_req`=1; on `imem_ack`, IR ← `imem_rdata`, go to DECODE. `imem_ack` outside FETCH is ignored.
- DECODE: selects and `abs_val` are driven from IR and held through EXEC/MEM.
- EXEC, ALU ops (0000–0110, 1100, 1101): `alu_control`=opcode, `rf_we`=1, `wb_sel`=0, dest Ry; PC ← PC+1 (mod 2^24).
- EXEC, JMP: PC ← `ra_data`; no write.
- EXEC, NOP: PC ← PC+1; no write.
- EXEC, reserved opcode: `illegal_op`=1 for one cycle, then treated as NOP.
- EXEC, LD/ST: latch `dmem_addr` ← `ra_data`, go to MEM.
- MEM: `dmem_req`=1, `dmem_we`=(ST). On `dmem_ack`: LD pulses `rf_we`=1 with `wb_sel`=1 and dest Rb; ST has no write. PC ← PC+1, go to FETCH.
- Outside EXEC, `alu_control`=1000 (NOP).

## Timing
- Reset values (cycle after `rst`): state=FETCH, `pc`=PC_RESET, IR=0, `alu_control`=1000, `abs_val`/selects/`dmem_addr`=0, and `rf_we`, `wb_sel`, `imem_req`, `dmem_req`, `dmem_we`, `illegal_op`=0.
- `rst` overrides everything, including mid-FETCH or mid-MEM. Requests drop next cycle, and a pending ack is discarded.
- Minimum latency with same-cycle ack: ALU/JMP/NOP = 3 cycles, LD/ST = 4 cycles.
- `rf_we` is registered and asserted exactly one cycle per writing instruction.
- PC wraps from 24'hFFFFFF to 0.
- `imem_req`/`dmem_req` stay high and stable until ack. An ack in the first request cycle is accepted.

## Structure
- Shared package `cpu_pkg`: opcode localparams, state enum, instruction field bit positions, NOP code 4'b1000, and XLEN=24.
- One sub-module, `cpu_instr_fields`: combinational split of IR into opcode/Ry/Ra/Rb/Imm plus the classification flags `is_alu`, `is_mem`, `is_jmp`, `is_reserved`.

## Test plan
- Reset then fetch 24'h0_3_1_2_00 (ADD R3←R1+R2) with immediate ack → `alu_control`=0000, ry/ra/rb=3/1/2, `rf_we` pulse in cycle 3, `pc`=1.
- ADDI 24'hC_5_4_0_7F → `alu_control`=1100, `abs_val`=8'h7F, dest 5.
- JMP with `ra_data`=24'h000040 → `pc`=24'h000040, no `rf_we`. With `pc`=24'hFFFFFF, a NOP → `pc`=0.
- LD (24'hA_0_2_6_00) with `ra_data`=24'h100 and `dmem_ack` delayed 3 cycles → `dmem_req` held 4 cycles, `dmem_addr`=24'h100, `dmem_we`=0, `rf_we`+`wb_sel`=1 on ack, dest 6. ST with the same fields → `dmem_we`=1, no `rf_we`.
- Reserved opcode 1110 → `illegal_op` one-cycle pulse, `pc`+1, no write.
- `rst` asserted during MEM wait → `dmem_req`=0 next cycle, `pc`=PC_RESET, and a late `dmem_ack` causes no `rf_we`.
